// File: rtl/exhaustive_resp_capture_if.sv
// exhaustive_resp_capture_if
//   Bundles the capture-stage signals for one N_IN-input, single-output DUT.
//   slave  : the capture block. It receives start, golden and dut_out, and
//            drives the pattern and result signals.
//   master : the controller/bench side, with the opposite directions.
//   Signals:
//     start          run request
//     golden         expected truth table; bit k is the expected output for pattern k
//     dut_out        DUT single-bit output
//     pattern        pattern driven to the DUT
//     busy, done     run status
//     truth          captured truth table
//     mismatch       set when truth differs from golden
//     first_fail_idx lowest failing pattern index
//     fail_count     number of failing patterns
//     signature      16-bit MISR signature; exists only when RESP_MISR_EN is defined
interface exhaustive_resp_capture_if #(
   parameter int N_IN = 3
);
   logic                 start;
   logic [(1<<N_IN)-1:0] golden;
   logic                 dut_out;
   logic [N_IN-1:0]      pattern;
   logic                 busy;
   logic                 done;
   logic [(1<<N_IN)-1:0] truth;
   logic                 mismatch;
   logic [N_IN-1:0]      first_fail_idx;
   logic [N_IN:0]        fail_count;
`ifdef RESP_MISR_EN
   logic [15:0]          signature;
`endif

   modport slave (
      input  start, golden, dut_out,
      output pattern, busy, done, truth, mismatch, first_fail_idx, fail_count
`ifdef RESP_MISR_EN
      , output signature
`endif
   );

   modport master (
      output start, golden, dut_out,
      input  pattern, busy, done, truth, mismatch, first_fail_idx, fail_count
`ifdef RESP_MISR_EN
      , input signature
`endif
   );
endinterface

// File: rtl/exhaustive_resp_capture.sv
// exhaustive_resp_capture
//   Steps an N_IN-input DUT through every input pattern. Each pattern is held
//   for SETTLE+1 cycles, and the DUT output is sampled on the last of those
//   cycles. The block builds the captured truth table and compares it, bit by
//   bit, against a golden table that is latched when the run starts.
//   Optional feature: define RESP_MISR_EN to add a 16-bit MISR signature
//   (polynomial 0x1021) over the sampled outputs.
//   Ports:
//     CK     rising-edge clock
//     reset  asynchronous, active-high; clears all state
//     cap    capture interface, slave modport (see exhaustive_resp_capture_if)
//   Parameters: N_IN (1..8) is the DUT input width; SETTLE (0..15) is the
//   number of settle cycles per pattern.
module exhaustive_resp_capture #(
   parameter int N_IN   = 3,
   parameter int SETTLE = 1
) (
   input  logic                        CK,
   input  logic                        reset,
   exhaustive_resp_capture_if.slave    cap
);

   localparam int              NPAT     = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_IDX = '1;
   localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [NPAT-1:0]   golden_q, golden_d;
   logic [NPAT-1:0]   truth_q, truth_d;
   logic              mism_q, mism_d;
   logic [N_IN-1:0]   ffi_q, ffi_d;
   logic [N_IN:0]     fcnt_q, fcnt_d;
`ifdef RESP_MISR_EN
   logic [15:0]       sig_q, sig_d;
   logic              fb;
`endif

   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         golden_q <= '0;
         truth_q  <= '0;
         mism_q   <= 1'b0;
         ffi_q    <= '0;
         fcnt_q   <= '0;
`ifdef RESP_MISR_EN
         sig_q    <= 16'hFFFF;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         golden_q <= golden_d;
         truth_q  <= truth_d;
         mism_q   <= mism_d;
         ffi_q    <= ffi_d;
         fcnt_q   <= fcnt_d;
`ifdef RESP_MISR_EN
         sig_q    <= sig_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      golden_d = golden_q;
      truth_d  = truth_q;
      mism_d   = mism_q;
      ffi_d    = ffi_q;
      fcnt_d   = fcnt_q;
`ifdef RESP_MISR_EN
      sig_d    = sig_q;
      fb       = sig_q[15] ^ cap.dut_out;
`endif
      case (state_q)
         // IDLE and DONE both accept start. Result registers hold until a
         // start is accepted, so DONE keeps presenting the last run.
         S_IDLE, S_DONE: begin
            if (cap.start) begin
               state_d  = S_RUN;
               golden_d = cap.golden;
               truth_d  = '0;
               mism_d   = 1'b0;
               ffi_d    = '0;
               fcnt_d   = '0;
               idx_d    = '0;
               cnt_d    = '0;
`ifdef RESP_MISR_EN
               sig_d    = 16'hFFFF;
`endif
            end
         end
         S_RUN: begin
            if (cnt_q == SETTLE_C) begin
               // Sample edge: all result registers update here, with no
               // extra pipeline stage.
               truth_d[idx_q] = cap.dut_out;
               if (cap.dut_out != golden_q[idx_q]) begin
                  fcnt_d = fcnt_q + (N_IN+1)'(1);
                  // A clear mismatch flag means this is the first failure
                  // of the run.
                  if (!mism_q) begin
                     ffi_d  = idx_q;
                     mism_d = 1'b1;
                  end
               end
`ifdef RESP_MISR_EN
               sig_d = {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
`endif
               cnt_d = '0;
               // On the last pattern, idx holds at all-ones instead of
               // wrapping, so pattern shows the final value in DONE.
               if (idx_q == LAST_IDX) state_d = S_DONE;
               else                   idx_d   = idx_q + N_IN'(1);
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // pattern[N_IN-1] connects to DUT input N[0]. The bit order is a wiring
   // choice, so no reversal is done here.
   assign cap.pattern        = idx_q;
   assign cap.busy           = (state_q == S_RUN);
   assign cap.done           = (state_q == S_DONE);
   assign cap.truth          = truth_q;
   assign cap.mismatch       = mism_q;
   assign cap.first_fail_idx = ffi_q;
   assign cap.fail_count     = fcnt_q;
`ifdef RESP_MISR_EN
   assign cap.signature      = sig_q;
`endif

endmodule

// File: tb/tb_exhaustive_resp_capture.sv
module tb_exhaustive_resp_capture;

   logic CK = 1'b0;
   logic reset = 1'b1;
   always #5 CK = ~CK;

   // Two instances: u1 has SETTLE=1 and u0 has SETTLE=0. cur selects which
   // one is stimulated and observed.
   exhaustive_resp_capture_if #(.N_IN(3)) if1 ();
   exhaustive_resp_capture_if #(.N_IN(3)) if0 ();

   exhaustive_resp_capture #(.N_IN(3), .SETTLE(1)) u1 (.CK(CK), .reset(reset), .cap(if1.slave));
   exhaustive_resp_capture #(.N_IN(3), .SETTLE(0)) u0 (.CK(CK), .reset(reset), .cap(if0.slave));

   logic       cur = 1'b1;
   logic       start_r = 1'b0;
   logic [1:0] mode_r = 2'd0;
   logic [7:0] gold_r = 8'h00;

   // DUT models: 0 parity, 1 parity with pattern 5 inverted, 2 tied 1, 3 tied 0
   function automatic logic model(input logic [1:0] m, input logic [2:0] p);
      case (m)
         2'd0:    return ^p;
         2'd1:    return (^p) ^ (p == 3'd5);
         2'd2:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   assign if1.start   = start_r & cur;
   assign if0.start   = start_r & ~cur;
   assign if1.golden  = gold_r;
   assign if0.golden  = gold_r;
   assign if1.dut_out = model(mode_r, if1.pattern);
   assign if0.dut_out = model(mode_r, if0.pattern);

   logic       o_busy, o_done, o_mm;
   logic [2:0] o_pat, o_ffi;
   logic [7:0] o_truth;
   logic [3:0] o_fc;
   assign o_busy  = cur ? if1.busy : if0.busy;
   assign o_done  = cur ? if1.done : if0.done;
   assign o_mm    = cur ? if1.mismatch : if0.mismatch;
   assign o_pat   = cur ? if1.pattern : if0.pattern;
   assign o_ffi   = cur ? if1.first_fail_idx : if0.first_fail_idx;
   assign o_truth = cur ? if1.truth : if0.truth;
   assign o_fc    = cur ? if1.fail_count : if0.fail_count;
`ifdef RESP_MISR_EN
   logic [15:0] o_sig;
   assign o_sig = cur ? if1.signature : if0.signature;
`endif

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       sel;
      logic [1:0] mode;
      logic [7:0] golden;
      logic [7:0] truth;
      logic       mm;
      logic [2:0] ffi;
      logic [3:0] fc;
      int         cyc;
   } vec_t;

   vec_t vecs[6];

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy"}, 32'(o_busy), 0);
      chk({tag, "_done"}, 32'(o_done), 0);
      chk({tag, "_pattern"}, 32'(o_pat), 0);
      chk({tag, "_truth"}, 32'(o_truth), 0);
      chk({tag, "_mismatch"}, 32'(o_mm), 0);
      chk({tag, "_ffi"}, 32'(o_ffi), 0);
      chk({tag, "_fc"}, 32'(o_fc), 0);
`ifdef RESP_MISR_EN
      chk({tag, "_sig"}, 32'(o_sig), 32'h0000FFFF);
`endif
   endtask

   // Starts a run and counts busy cycles. restart_at > 0 pulses start
   // again during that busy cycle.
   task automatic run_vec(input vec_t v, input int restart_at, input string tag);
      int n;
      cur = v.sel; mode_r = v.mode; gold_r = v.golden;
      @(negedge CK); start_r = 1'b1;
      @(negedge CK); start_r = 1'b0;
      chk({tag, "_busy_at_start"}, 32'(o_busy), 1);
      chk({tag, "_pattern_at_start"}, 32'(o_pat), 0);
      n = 0;
      while (o_busy && n < 200) begin
         n++;
         start_r = (n == restart_at);
         @(negedge CK);
      end
      start_r = 1'b0;
      chk({tag, "_busy_cycles"}, 32'(n), 32'(v.cyc));
      chk({tag, "_done"}, 32'(o_done), 1);
      chk({tag, "_pattern_done"}, 32'(o_pat), 7);
      chk({tag, "_truth"}, 32'(o_truth), 32'(v.truth));
      chk({tag, "_mismatch"}, 32'(o_mm), 32'(v.mm));
      chk({tag, "_ffi"}, 32'(o_ffi), 32'(v.ffi));
      chk({tag, "_fc"}, 32'(o_fc), 32'(v.fc));
   endtask

   initial begin
      //                sel   mode  golden  truth   mm    ffi   fc     cyc
      vecs[0] = '{1'b1, 2'd0, 8'h96, 8'h96, 1'b0, 3'd0, 4'd0, 16};  // parity clean
      vecs[1] = '{1'b1, 2'd1, 8'h96, 8'hB6, 1'b1, 3'd5, 4'd1, 16};  // one bad pattern
      vecs[2] = '{1'b0, 2'd2, 8'h00, 8'hFF, 1'b1, 3'd0, 4'd8, 8};   // tied 1, SETTLE=0
      vecs[3] = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b0, 3'd0, 4'd0, 16};  // tied 0
      vecs[4] = '{1'b0, 2'd0, 8'h69, 8'h96, 1'b1, 3'd0, 4'd8, 8};   // all fail, SETTLE=0
      vecs[5] = '{1'b1, 2'd0, 8'h1E, 8'h96, 1'b1, 3'd3, 4'd2, 16};  // fails at 3 and 7
   end

   initial begin
      int n;
      repeat (3) @(negedge CK);
      cur = 1'b1; check_reset_vals("rst_u1");
      cur = 1'b0; check_reset_vals("rst_u0");
      reset = 1'b0;
      @(negedge CK);

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i], 0, $sformatf("vec%0d", i));
`ifdef RESP_MISR_EN
         if (vecs[i].mode == 2'd3) chk($sformatf("vec%0d_sig", i), 32'(o_sig), 32'h0000E1F0);
`endif
      end

      // Holding start high in DONE: the first accepted start clears results.
      @(negedge CK); start_r = 1'b1;
      @(negedge CK);
      chk("hold_busy", 32'(o_busy), 1);
      chk("hold_done", 32'(o_done), 0);
      chk("hold_pattern", 32'(o_pat), 0);
      chk("hold_truth_clr", 32'(o_truth), 0);
      chk("hold_fc_clr", 32'(o_fc), 0);
      chk("hold_mm_clr", 32'(o_mm), 0);
      @(negedge CK); start_r = 1'b0;
      n = 0;
      while (!o_done && n < 200) begin n++; @(negedge CK); end
      chk("hold_rerun_done", 32'(o_done), 1);
      chk("hold_rerun_fc", 32'(o_fc), 2);
      chk("hold_rerun_ffi", 32'(o_ffi), 3);

      // A start pulse during cycle 4 of a run must be ignored.
      run_vec(vecs[0], 4, "restart");

      // Asynchronous reset asserted between clock edges in cycle 7.
      cur = 1'b1; mode_r = 2'd0; gold_r = 8'h96;
      @(negedge CK); start_r = 1'b1;
      @(negedge CK); start_r = 1'b0;
      repeat (6) @(negedge CK);
      chk("mid_truth_partial", 32'(o_truth), 32'h06);
      chk("mid_pattern", 32'(o_pat), 3);
      #2 reset = 1'b1;
      #1 check_reset_vals("async_rst");
      @(negedge CK); reset = 1'b0;
      run_vec(vecs[1], 0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
